// File: rtl/histo_readout_if.sv
// Byte stream between the histogram reader and the host transmit path.
// The master drives data/valid; the sink answers with ready.
interface histo_readout_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/histo_readout.sv
// Serialises the bin and IPI histograms as one framed, XOR-checksummed byte stream.
// Define HISTO_READOUT_SNAPSHOT_EN to send a coherent copy taken when start is accepted.
module histo_readout #(
    parameter int         NBINS = 8,
    parameter int         NIPI  = 64,
    parameter logic [7:0] HDR   = 8'hA5
) (
    input  logic                  clkin,
    input  logic                  nrst,
    input  logic [NBINS*32-1:0]   histo_flat,
    input  logic [NIPI*32-1:0]    ipi_flat,
    input  logic                  start,
    input  logic                  clear_after,
    histo_readout_if.master       tx,
    output logic                  busy,
    output logic                  done,
    output logic                  resethist
);
    localparam int         NW       = NBINS + NIPI;
    localparam logic [7:0] CNT_BYTE = 8'(NW);
    localparam logic [7:0] LAST_IDX = 8'(NW - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_CNT  = 3'd2,
        S_WORD = 3'd3,
        S_CSUM = 3'd4,
        S_CLR  = 3'd5
    } state_t;

    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t            state_q, state_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              resethist_q, resethist_d;
    logic [7:0]        word_idx_q, word_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [7:0]        csum_q, csum_d;
    logic [23:0]       shift_q, shift_d;
    logic              clr_q, clr_d;
    logic [NW*32-1:0]  live_s;
    logic [NW*32-1:0]  src_s;
    logic [7:0]        fetch_idx_s;
    logic [31:0]       fetch_word_s;
    logic              hs_s;

    assign live_s = {ipi_flat, histo_flat};
    assign hs_s   = tx_valid_q & tx.tx_ready;

`ifdef HISTO_READOUT_SNAPSHOT_EN
    logic [NW*32-1:0] snap_q, snap_d;
    assign src_s = snap_q;
`else
    assign src_s = live_s;
`endif

    // Select the word whose byte 0 would be loaded on the next handshake.
    always_comb begin
        fetch_idx_s = 8'd0;
        if ((state_q == S_WORD) && (word_idx_q != LAST_IDX)) begin
            fetch_idx_s = word_idx_q + 8'd1;
        end else begin
            fetch_idx_s = 8'd0;
        end
        fetch_word_s = src_s[{fetch_idx_s, 5'd0} +: 32];
    end

    // Next-state and next-output logic of the frame sequencer.
    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        resethist_d = 1'b0;
        word_idx_d  = word_idx_q;
        byte_idx_d  = byte_idx_q;
        csum_d      = csum_q;
        shift_d     = shift_q;
        clr_d       = clr_q;
`ifdef HISTO_READOUT_SNAPSHOT_EN
        snap_d      = snap_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_HDR;
                    tx_data_d  = HDR;
                    tx_valid_d = 1'b1;
                    busy_d     = 1'b1;
                    csum_d     = 8'd0;
                    clr_d      = clear_after;
                    word_idx_d = 8'd0;
                    byte_idx_d = 2'd0;
`ifdef HISTO_READOUT_SNAPSHOT_EN
                    snap_d     = live_s;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HDR: begin
                if (hs_s) begin
                    state_d   = S_CNT;
                    tx_data_d = CNT_BYTE;
                end else begin
                    state_d = S_HDR;
                end
            end
            S_CNT: begin
                if (hs_s) begin
                    state_d    = S_WORD;
                    csum_d     = csum_step(csum_q, tx_data_q);
                    tx_data_d  = fetch_word_s[7:0];
                    shift_d    = fetch_word_s[31:8];
                    word_idx_d = 8'd0;
                    byte_idx_d = 2'd0;
                end else begin
                    state_d = S_CNT;
                end
            end
            S_WORD: begin
                if (hs_s) begin
                    csum_d = csum_step(csum_q, tx_data_q);
                    if (byte_idx_q != 2'd3) begin
                        tx_data_d  = shift_q[7:0];
                        shift_d    = {8'd0, shift_q[23:8]};
                        byte_idx_d = byte_idx_q + 2'd1;
                    end else if (word_idx_q == LAST_IDX) begin
                        state_d   = S_CSUM;
                        tx_data_d = csum_step(csum_q, tx_data_q);
                    end else begin
                        // Capture the whole next word now so its bytes cannot tear.
                        word_idx_d = word_idx_q + 8'd1;
                        byte_idx_d = 2'd0;
                        tx_data_d  = fetch_word_s[7:0];
                        shift_d    = fetch_word_s[31:8];
                    end
                end else begin
                    state_d = S_WORD;
                end
            end
            S_CSUM: begin
                if (hs_s) begin
                    tx_valid_d = 1'b0;
                    done_d     = 1'b1;
                    if (clr_q) begin
                        state_d     = S_CLR;
                        resethist_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    state_d = S_CSUM;
                end
            end
            S_CLR: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d    = S_IDLE;
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clkin) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            tx_data_q   <= 8'd0;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            resethist_q <= 1'b0;
            word_idx_q  <= 8'd0;
            byte_idx_q  <= 2'd0;
            csum_q      <= 8'd0;
            shift_q     <= 24'd0;
            clr_q       <= 1'b0;
`ifdef HISTO_READOUT_SNAPSHOT_EN
            snap_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            resethist_q <= resethist_d;
            word_idx_q  <= word_idx_d;
            byte_idx_q  <= byte_idx_d;
            csum_q      <= csum_d;
            shift_q     <= shift_d;
            clr_q       <= clr_d;
`ifdef HISTO_READOUT_SNAPSHOT_EN
            snap_q      <= snap_d;
`endif
        end
    end

    assign tx.tx_data  = tx_data_q;
    assign tx.tx_valid = tx_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign resethist   = resethist_q;
endmodule
